// File: rtl/jedro_1_defines.sv
// Shared definitions for the jedro_1 instruction fetch unit: default boot
// address, prefetch entry layout and instruction alignment mask.
package jedro_1_defines;

    localparam int unsigned IFU_ADDR_WIDTH = 32;
    localparam int unsigned IFU_DATA_WIDTH = 32;

    localparam logic [31:0] DEFAULT_BOOT_ADDR = 32'h0000_0000;
    localparam logic [31:0] INSTR_ALIGN_MASK  = 32'hFFFF_FFFC;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/jedro_1_ifu_fifo.sv
// Generic synchronous FIFO with push, pop, flush and occupancy count.
// Flush wins over push/pop; a push into a full FIFO is only accepted with a pop.
module jedro_1_ifu_fifo
    import jedro_1_defines::*;
#(
    parameter type         T     = fetch_entry_t,
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk_i,
    input  logic                   rstn_i,
    input  logic                   push_i,
    input  T                       data_i,
    input  logic                   pop_i,
    input  logic                   flush_i,
    output T                       data_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    T               mem [DEPTH];
    logic [PW-1:0]  rd_ptr;
    logic [PW-1:0]  wr_ptr;
    logic [CW-1:0]  count;
    logic           do_push;
    logic           do_pop;

    assign do_pop  = pop_i && (count != '0);
    assign do_push = push_i && ((count != CW'(DEPTH)) || do_pop);

    assign data_o  = mem[rd_ptr];
    assign count_o = count;

    // Storage, pointers and occupancy.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (flush_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= data_i;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + CW'(1);
            end else if (do_pop && !do_push) begin
                count <= count - CW'(1);
            end
        end
    end

endmodule

// File: rtl/jedro_1_ifu.sv
// jedro_1 instruction fetch unit: owns the fetch PC, issues sequential ROM
// reads under a credit limit, buffers words and handles jump redirects.
module jedro_1_ifu
    import jedro_1_defines::*;
#(
    parameter int unsigned           DATA_WIDTH = IFU_DATA_WIDTH,
    parameter int unsigned           ADDR_WIDTH = IFU_ADDR_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] BOOT_ADDR  = DEFAULT_BOOT_ADDR,
    parameter int unsigned           FIFO_DEPTH = 4
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    output logic [ADDR_WIDTH-1:0] instr_mem_addr_o,
    output logic                  instr_mem_en_o,
    input  logic [DATA_WIDTH-1:0] instr_mem_rdata_i,
    input  logic                  jmp_instr_i,
    input  logic [ADDR_WIDTH-1:0] jmp_addr_i,
    output logic [DATA_WIDTH-1:0] instr_o,
    output logic [ADDR_WIDTH-1:0] instr_addr_o,
    output logic                  instr_valid_o,
    input  logic                  decoder_ready_i
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    logic [ADDR_WIDTH-1:0] fetch_pc;
    logic [ADDR_WIDTH-1:0] inflight_addr_q;
    logic                  inflight_q;
    logic                  stale_q;
    logic [CW-1:0]         count;
    logic                  credit_ok;
    logic                  issue;
    logic                  push;
    logic                  pop;
    fetch_entry_t          push_entry;
    fetch_entry_t          head;

    // An in-flight word already owns a slot; same-cycle pops give no credit.
    always_comb begin
        credit_ok = (count + CW'(inflight_q)) < CW'(FIFO_DEPTH);
        issue     = rstn_i && !jmp_instr_i && credit_ok;
        push      = inflight_q && !stale_q;
        pop       = (count != '0) && decoder_ready_i;
        push_entry.addr  = inflight_addr_q;
        push_entry.instr = instr_mem_rdata_i;
    end

    assign instr_mem_addr_o = fetch_pc;
    assign instr_mem_en_o   = issue;
    assign instr_valid_o    = (count != '0);
    assign instr_o          = head.instr;
    assign instr_addr_o     = head.addr;

    // Fetch PC, outstanding-request tracking and stale-response marker.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            fetch_pc        <= BOOT_ADDR;
            inflight_q      <= 1'b0;
            inflight_addr_q <= '0;
            stale_q         <= 1'b0;
        end else begin
            if (jmp_instr_i) begin
                fetch_pc <= jmp_addr_i & INSTR_ALIGN_MASK[ADDR_WIDTH-1:0];
            end else if (issue) begin
                fetch_pc <= fetch_pc + ADDR_WIDTH'(4);
            end
            if (issue) begin
                inflight_addr_q <= fetch_pc;
            end
            inflight_q <= issue;
            stale_q    <= jmp_instr_i ? inflight_q : 1'b0;
        end
    end

    jedro_1_ifu_fifo #(
        .T     (fetch_entry_t),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rstn_i  (rstn_i),
        .push_i  (push),
        .data_i  (push_entry),
        .pop_i   (pop),
        .flush_i (jmp_instr_i),
        .data_o  (head),
        .count_o (count)
    );

endmodule

// File: doc/jedro_1_ifu.md
# jedro_1_ifu

Instruction fetch unit for the jedro_1 core, sitting directly upstream of the decoder. It owns the fetch program counter and issues sequential word reads to the synchronous instruction ROM (one-cycle read latency). Returned words are buffered in a small prefetch FIFO and handed to the decoder over a valid/ready handshake. A jump/branch redirect flushes buffered and in-flight fetches.

## Interface
Parameters:
- DATA_WIDTH, 32, instruction width.
- ADDR_WIDTH, 32, byte-address width.
- BOOT_ADDR, 32'h0, first fetch address after reset.
- FIFO_DEPTH, 4, prefetch entries; power of two, at least 2.

Ports (one clock; reset is asynchronous and active-low):
- clk_i  in  1  core clock.
- rstn_i  in  1  asynchronous active-low reset.
- instr_mem_addr_o  out  ADDR_WIDTH  ROM byte address; wired to ram_read_io addr.
- instr_mem_en_o  out  1  ROM read enable.
- instr_mem_rdata_i  in  DATA_WIDTH  ROM data, valid the cycle after an enabled request.
- jmp_instr_i  in  1  redirect request from execute.
- jmp_addr_i  in  ADDR_WIDTH  redirect target.
- instr_o  out  DATA_WIDTH  head instruction to decoder.
- instr_addr_o  out  ADDR_WIDTH  PC of instr_o.
- instr_valid_o  out  1  instr_o/instr_addr_o valid.
- decoder_ready_i  in  1  decoder accepts head this cycle.

## Operation
- Registers: fetch_pc; inflight_q plus inflight_addr_q (one outstanding request at most per cycle); stale_q (drop next response); FIFO entries of {addr, instr}; count.
- Issue rule: instr_mem_en_o = !jmp_instr_i && (count + inflight_q) < FIFO_DEPTH. Pops in the same cycle do not add credit (conservative). The rule still sustains one instruction per cycle.
- On issue: instr_mem_addr_o = fetch_pc; fetch_pc += 4 at the edge; inflight_q <= 1; inflight_addr_q <= fetch_pc.
- Response: in the cycle after an issue, if stale_q == 0, {inflight_addr_q, instr_mem_rdata_i} is pushed at the edge. If stale_q == 1, the response is discarded.
- Pop: when instr_valid_o && decoder_ready_i, the head is removed at the edge. Push and pop in the same cycle keep count unchanged.
- instr_valid_o = (count != 0). instr_o and instr_addr_o show the head entry.
- Redirect (jmp_instr_i sampled at edge):
  - fetch_pc <= {jmp_addr_i[ADDR_WIDTH-1:2], 2'b00}; misaligned low bits are dropped.
  - FIFO is emptied.
  - stale_q <= inflight_q, which kills a response arriving next cycle.
  - No issue occurs in the redirect cycle.
  - Redirect takes priority over a simultaneous push or pop. A pop in that cycle is still considered consumed by the decoder.
- fetch_pc wraps modulo 2^ADDR_WIDTH with no fault.

## Timing
- Reset values: fetch_pc = BOOT_ADDR, instr_mem_addr_o = BOOT_ADDR, instr_mem_en_o = 0, instr_valid_o = 0, instr_o = 0, instr_addr_o = 0, count = 0, inflight_q = 0, stale_q = 0.
- Reset mid-operation clears all state immediately (asynchronously), not at the next edge.
- First request: the first cycle after rstn_i deasserts (en = 1, addr = BOOT_ADDR).
- Fetch latency: request in cycle N → ROM data in N+1 → instr_valid_o high in N+2.
- Redirect latency: redirect sampled at edge E → request to target in cycle E+1 → target on instr_o in cycle E+3 (first cycle after edge E+2).
- Full: with decoder_ready_i = 0, exactly FIFO_DEPTH words are requested, then en stays 0. No word is lost or duplicated on release.
- Empty: instr_valid_o = 0. decoder_ready_i is ignored.

## Structure
- Package jedro_1_defines holds:
  - the BOOT_ADDR default;
  - the typedef fetch_entry_t {addr, instr};
  - the constant INSTR_ALIGN_MASK.
- Sub-module jedro_1_ifu_fifo: generic synchronous FIFO with push, pop, flush and count outputs, parameterised on entry type and depth.
- jedro_1_ifu holds the PC, credit logic and stale tracking.

## Test plan
- Reset, ROM holding five addi words at 0x0–0x10, ready = 1 → requests at 0,4,8,0xC,0x10 on consecutive cycles; instr_valid_o rises 2 cycles after the first request; instructions appear in order, one per cycle, with matching instr_addr_o. In-core, x1 = 15 after the sequence.
- ready = 0 for 10 cycles from reset → exactly 4 requests (0x0–0xC), then en = 0. Release → 4 pops in 4 cycles with no gap; next request is 0x10.
- Streaming, jmp_instr_i = 1 with jmp_addr_i = 0x40 while a response is in flight → FIFO flushed and stale word dropped; next instr_addr_o is 0x40, 3 cycles after the redirect edge.
- Redirect while FIFO is full and ready = 0 → count goes to 0; fetch resumes at the target.
- jmp_addr_i = 0x42 → fetch at 0x40.
- rstn_i asserted mid-stream between edges → all outputs take reset values immediately; after release, fetch restarts at BOOT_ADDR.
